// File: rtl/mc_controller_p.sv
// Multicycle ARM-subset controller: main FSM, ALU decoder, condition check and
// NZCV flag register. Instr carries instruction bits [31:12], so bit k of the
// instruction is Instr[k-12].
module mc_controller_p #(
  parameter int unsigned ALUCTL_W    = 3,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [19:0]         Instr,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          RegSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOrr = 3'd3;
  localparam logic [2:0] AluEor = 3'd4;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       flags_en;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit;
  logic [3:0] cmd;

  logic [2:0] alu_op, alu_ctl;
  logic       no_write, legal, arith;
  logic       cond_ex;
  logic       pc_w, mem_w, reg_w, ir_w;

  // Register numbers (Rn/Rd) are routed by the datapath, not used here.
  logic unused_regs;
  assign unused_regs = ^Instr[7:0];

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign i_bit = Instr[13];
  assign cmd   = Instr[12:9];
  assign u_bit = Instr[11];
  assign s_bit = Instr[8];

  // ALU decode: map cmd to an operation; compare/test forms suppress the write.
  always_comb begin
    alu_op   = AluAdd;
    no_write = 1'b0;
    legal    = 1'b1;
    arith    = 1'b0;
    case (cmd)
      4'b0100: begin alu_op = AluAdd; arith = 1'b1; end
      4'b0010: begin alu_op = AluSub; arith = 1'b1; end
      4'b0000: alu_op = AluAnd;
      4'b1100: alu_op = AluOrr;
      4'b0001: begin alu_op = AluEor; legal = (ALUCTL_W >= 3); end
      4'b1010: begin alu_op = AluSub; arith = 1'b1; no_write = 1'b1; end
      4'b1011: begin alu_op = AluAdd; arith = 1'b1; no_write = 1'b1; end
      4'b1000: begin alu_op = AluAnd; no_write = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (!legal) alu_op = AluAdd;
  end

  // Condition check against the stored NZCV flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Logic ops leave C and V untouched.
  assign flags_en = ((state_q == StExecR) || (state_q == StExecI)) & s_bit & cond_ex & legal;
  assign flags_d  = {ALUFlags[3:2], arith ? ALUFlags[1:0] : flags_q[1:0]};

  // Flag register, loaded at the end of an executing ALU instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= RESET_FLAGS;
    end else if (flags_en) begin
      flags_q <= flags_d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = i_bit ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = s_bit ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR,
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  // Per-state control outputs; strobes are gated off below while reset is held.
  always_comb begin
    pc_w      = 1'b0;
    mem_w     = 1'b0;
    reg_w     = 1'b0;
    ir_w      = 1'b0;
    AdrSrc    = 1'b0;
    RegSrc    = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_ctl   = AluAdd;
    unique case (state_q)
      StFetch: begin
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = 2'b01;
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        alu_ctl = u_bit ? AluAdd : AluSub;
      end
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w     = cond_ex;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex;
        RegSrc = 2'b10;
      end
      StExecR:  alu_ctl = alu_op;
      StExecI: begin
        ALUSrcB = 2'b01;
        alu_ctl = alu_op;
      end
      StAluWb:  reg_w = cond_ex & ~no_write & legal;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = cond_ex;
        RegSrc    = 2'b01;
      end
      default: ;
    endcase
  end

  assign PCWrite    = pc_w & reset;
  assign MemWrite   = mem_w & reset;
  assign RegWrite   = reg_w & reset;
  assign IRWrite    = ir_w & reset;
  assign ImmSrc     = op;
  assign ALUControl = alu_ctl[ALUCTL_W-1:0];
  assign State      = state_q;

endmodule

// File: tb/tb_mc_controller_p.sv
// Bench for mc_controller_p: two instances (3-bit ALU control with clear reset
// flags, 2-bit ALU control with Z set on reset) share one stimulus stream.
module tb_mc_controller_p;

  localparam logic [3:0] RF0 = 4'b0000;
  localparam logic [3:0] RF1 = 4'b0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;

  logic       pcw [2];
  logic       mw [2];
  logic       rw [2];
  logic       irw [2];
  logic       adr [2];
  logic [1:0] rsrc [2];
  logic [1:0] srca [2];
  logic [1:0] srcb [2];
  logic [1:0] res [2];
  logic [1:0] imm [2];
  logic [3:0] state [2];
  logic [2:0] alc3;
  logic [1:0] alc2;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: step within the current instruction and per-instance flags.
  int         m_k = 0;
  logic [3:0] mflags [2] = '{RF0, RF1};

  // Traces of the last instruction run (instance 0 unless suffixed 2).
  logic [31:0] st_tr;
  logic [7:0]  rw_tr, pc_tr, mw_tr, rw2_tr, pc2_tr;
  logic [2:0]  exec_alc;

  always #5 clk = ~clk;

  mc_controller_p #(.ALUCTL_W(3), .RESET_FLAGS(RF0)) dut3 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw[0]), .MemWrite(mw[0]), .RegWrite(rw[0]), .IRWrite(irw[0]),
    .AdrSrc(adr[0]), .RegSrc(rsrc[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
    .ResultSrc(res[0]), .ImmSrc(imm[0]), .ALUControl(alc3), .State(state[0])
  );

  mc_controller_p #(.ALUCTL_W(2), .RESET_FLAGS(RF1)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw[1]), .MemWrite(mw[1]), .RegWrite(rw[1]), .IRWrite(irw[1]),
    .AdrSrc(adr[1]), .RegSrc(rsrc[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
    .ResultSrc(res[1]), .ImmSrc(imm[1]), .ALUControl(alc2), .State(state[1])
  );

  // Instruction timeline from the latency rules: which state is step k.
  function automatic int seq_state(input logic [19:0] ins, input int k);
    logic [1:0] op;
    op = ins[15:14];
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (k == 2) begin
      if (op == 2'b01) return 2;
      if (op == 2'b00) return ins[13] ? 7 : 6;
      if (op == 2'b10) return 9;
    end
    if (k == 3) begin
      if (op == 2'b01) return ins[8] ? 3 : 5;
      if (op == 2'b00) return 8;
    end
    if (k == 4 && op == 2'b01 && ins[8]) return 4;
    return 15;
  endfunction

  function automatic int seq_len(input logic [19:0] ins);
    case (ins[15:14])
      2'b01:   return ins[8] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, -1 unknown.
  function automatic int op_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100, 4'b1011: return 0;
      4'b0010, 4'b1010: return 1;
      4'b0000, 4'b1000: return 2;
      4'b1100:          return 3;
      4'b0001:          return 4;
      default:          return -1;
    endcase
  endfunction

  function automatic bit is_legal(input int i, input logic [3:0] cmd);
    int o;
    o = op_of(cmd);
    return (o >= 0) && !(o == 4 && i == 1);
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [21:0] pack(
      input logic [3:0] st, input logic [2:0] alc, input logic [1:0] im,
      input logic [1:0] rs, input logic [1:0] sb, input logic [1:0] sa,
      input logic [1:0] rg, input logic ad, input logic ir, input logic r,
      input logic m, input logic p);
    return {st, alc, im, rs, sb, sa, rg, ad, ir, r, m, p};
  endfunction

  function automatic logic [21:0] model_exp(input int i);
    int st, o;
    bit ce, lg, p, m, r, ir, ad;
    logic [1:0] rg, sa, sb, rs;
    logic [2:0] alc;
    st = seq_state(Instr, m_k);
    ce = cond_ok(Instr[19:16], mflags[i]);
    lg = is_legal(i, Instr[12:9]);
    o  = op_of(Instr[12:9]);
    {p, m, r, ir, ad} = 5'b0;
    {rg, sa, sb, rs} = 8'b0;
    alc = 3'd0;
    case (st)
      0: begin ir = 1; p = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rg = 2'b01; end
      2: begin sb = 2'b01; alc = Instr[11] ? 3'd0 : 3'd1; end
      3: ad = 1;
      4: begin rs = 2'b01; r = ce; end
      5: begin ad = 1; m = ce; rg = 2'b10; end
      6: alc = lg ? 3'(o) : 3'd0;
      7: begin sb = 2'b01; alc = lg ? 3'(o) : 3'd0; end
      8: r = ce && lg && !(Instr[12:9] inside {4'b1010, 4'b1011, 4'b1000});
      9: begin sb = 2'b01; rs = 2'b10; p = ce; rg = 2'b01; end
      default: ;
    endcase
    if (!reset) {p, m, r, ir} = 4'b0;
    return pack(4'(st), alc, Instr[15:14], rs, sb, sa, rg, ad, ir, r, m, p);
  endfunction

  function automatic logic [21:0] dut_act(input int i);
    logic [2:0] a;
    a = (i == 0) ? alc3 : {1'b0, alc2};
    return pack(state[i], a, imm[i], res[i], srcb[i], srca[i], rsrc[i], adr[i], irw[i],
                rw[i], mw[i], pcw[i]);
  endfunction

  function automatic logic [3:0] flag_next(input int i);
    int st, o;
    st = seq_state(Instr, m_k);
    o  = op_of(Instr[12:9]);
    if ((st == 6 || st == 7) && Instr[8] && cond_ok(Instr[19:16], mflags[i]) &&
        is_legal(i, Instr[12:9]))
      return {ALUFlags[3:2], (o <= 1) ? ALUFlags[1:0] : mflags[i][1:0]};
    return mflags[i];
  endfunction

  // Model advance: one step per clock, flags taken at the end of execute.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k       <= 0;
      mflags[0] <= RF0;
      mflags[1] <= RF1;
    end else begin
      mflags[0] <= flag_next(0);
      mflags[1] <= flag_next(1);
      m_k       <= (m_k + 1 >= seq_len(Instr)) ? 0 : m_k + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [21:0] e, a;
      e = model_exp(i);
      a = dut_act(i);
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check dut%0d t=%0t instr=%h actual=%h required=%h",
                 i, $time, Instr, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run one instruction from FETCH back to FETCH, recording traces.
  task automatic run(input logic [19:0] ins, input logic [3:0] af);
    int st;
    bit done;
    Instr = ins;
    st_tr = '0; rw_tr = '0; pc_tr = '0; mw_tr = '0; rw2_tr = '0; pc2_tr = '0;
    exec_alc = '0;
    done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      st = seq_state(Instr, m_k);
      ALUFlags = (st == 6 || st == 7) ? af : 4'($urandom);
      #1;
      st_tr  = {st_tr[27:0], state[0]};
      rw_tr  = {rw_tr[6:0], rw[0]};
      pc_tr  = {pc_tr[6:0], pcw[0]};
      mw_tr  = {mw_tr[6:0], mw[0]};
      rw2_tr = {rw2_tr[6:0], rw[1]};
      pc2_tr = {pc2_tr[6:0], pcw[1]};
      if (state[0] == 4'd6 || state[0] == 4'd7) exec_alc = alc3;
      @(posedge clk);
      #1;
      if (m_k == 0) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout instr=%h actual=step%0d required=step0", ins, m_k);
    end
  endtask

  localparam int NT = 26;
  logic [19:0] tbl_i [NT] = '{
    20'hE5001, 20'hE0402, 20'hE0002, 20'hE1802, 20'hE1700, 20'hE1100, 20'h2A000,
    20'h4A000, 20'hE0301, 20'h4A000, 20'hE1B00, 20'hEC000, 20'h11530, 20'h0A000,
    20'hCA000, 20'hDA000, 20'h8A000, 20'h9A000, 20'hAA000, 20'hBA000, 20'h6A000,
    20'h7A000, 20'h5A000, 20'h3A000, 20'h1A000, 20'hFA000};
  logic [3:0] tbl_f [NT] = '{
    4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h8, 4'h0, 4'h0, 4'h5, 4'h0, 4'hF, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("reset_state", 32'(state[0]), 32'h0);
    lit("reset_strobes", {28'h0, pcw[0], mw[0], rw[0], irw[0]}, 32'h0);
    reset = 1'b1;
    #1;
    lit("release_fetch_strobes", {30'h0, irw[0], pcw[0]}, 32'h3);

    // Z clear in dut3, set in dut2 straight out of reset.
    run(20'h0A000, 4'h0);
    lit("beq_states", st_tr, 32'h019);
    lit("beq_z0_pcwrite", 32'(pc_tr), 32'b100);
    lit("beq_z1_pcwrite", 32'(pc2_tr), 32'b101);

    run(20'hE2802, 4'h0);
    lit("add_states", st_tr, 32'h0178);
    lit("add_regwrite", 32'(rw_tr), 32'b0001);
    lit("add_aluctl", 32'(exec_alc), 32'h0);

    run(20'hE5901, 4'h0);
    lit("ldr_states", st_tr, 32'h01234);
    lit("ldr_regwrite", 32'(rw_tr), 32'b00001);

    run(20'hE5801, 4'h0);
    lit("str_states", st_tr, 32'h0125);
    lit("str_memwrite", 32'(mw_tr), 32'b0001);

    run(20'h12802, 4'h0);
    lit("addne_z0_regwrite", 32'(rw_tr), 32'b0001);
    lit("addne_z1_regwrite", 32'(rw2_tr), 32'b0000);

    run(20'hE1530, 4'b0110);
    lit("cmp_states", st_tr, 32'h0168);
    lit("cmp_regwrite", 32'(rw_tr), 32'b0000);
    run(20'h0A000, 4'h0);
    lit("beq_after_cmp", 32'(pc_tr), 32'b101);
    lit("beq_after_cmp_w2", 32'(pc2_tr), 32'b101);

    run(20'hE0201, 4'h0);
    lit("eor_aluctl", 32'(exec_alc), 32'b100);
    lit("eor_regwrite", 32'(rw_tr), 32'b0001);
    lit("eor_w2_regwrite", 32'(rw2_tr), 32'b0000);

    for (int t = 0; t < NT; t++) run(tbl_i[t], tbl_f[t]);

    // Make flags non-reset, then abort a SUB in EXECR with reset.
    run(20'hE1530, 4'b0110);
    Instr = 20'hE0402;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    lit("pre_abort_state", 32'(state[0]), 32'h6);
    #2;
    reset = 1'b0;
    #1;
    lit("abort_state", 32'(state[0]), 32'h0);
    lit("abort_strobes", {28'h0, pcw[0], mw[0], rw[0], irw[0]}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run(20'h0A000, 4'h0);
    lit("abort_flags_beq", 32'(pc_tr), 32'b100);
    lit("abort_flags_beq_w2", 32'(pc2_tr), 32'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
